// File: rtl/pwm_pkg.sv
// Shared defaults and step-direction encoding for the PWM duty bank.
package pwm_pkg;

  localparam int PWM_N_CH     = 3;
  localparam int PWM_CW       = 4;
  localparam int PWM_DUTY_MAX = 10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pwm_duty_bank_if.sv
// Control and output bundle of the PWM duty bank; master drives steps, slave is the bank.
interface pwm_duty_bank_if #(
  parameter int N_CH = 3,
  parameter int CW   = 4
);

  logic                 INCR;
  logic                 DIR;
  logic [N_CH-1:0]      SEL;
  logic                 WRAP;
  logic [N_CH*CW-1:0]   DUTY;
  logic [N_CH-1:0]      LED_OUT;
  logic                 PER_STRB;

  modport master (
    output INCR, DIR, SEL, WRAP,
    input  DUTY, LED_OUT, PER_STRB
  );

  modport slave (
    input  INCR, DIR, SEL, WRAP,
    output DUTY, LED_OUT, PER_STRB
  );

endinterface

// File: rtl/pwm_duty_ch.sv
// One PWM channel: pending duty with up/down stepping, active duty, registered LED compare.
// Macro PWM_SHADOW_EN: active duty reloads from pending only at the period strobe.
module pwm_duty_ch
  import pwm_pkg::*;
#(
  parameter int CW       = 4,
  parameter int DUTY_MAX = 10,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  input  logic          i_incr,
  input  logic          i_dir,
  input  logic          i_wrap,
  input  logic          i_sel,
  input  logic          i_strb,
  input  logic [CW-1:0] i_cnt,
  output logic [CW-1:0] o_duty,
  output logic          o_led
);

  localparam logic [CW-1:0] MAX = CW'(DUTY_MAX);

  logic [CW-1:0] r_pend;
  logic [CW-1:0] w_pend_nxt;
  logic [CW-1:0] w_act;
  logic          w_on;
  logic          r_led;

  // Boundary cases resolve to a legal value in one step, so nothing out of range is ever stored.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_incr && i_sel) begin
      if (i_dir == DIR_UP) begin
        if (r_pend == MAX) w_pend_nxt = i_wrap ? '0 : MAX;
        else               w_pend_nxt = r_pend + CW'(1);
      end else begin
        if (r_pend == '0)  w_pend_nxt = i_wrap ? MAX : '0;
        else               w_pend_nxt = r_pend - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) r_pend <= '0;
    else          r_pend <= w_pend_nxt;
  end

`ifdef PWM_SHADOW_EN
  logic [CW-1:0] r_act;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n)    r_act <= '0;
    else if (i_strb) r_act <= r_pend;
  end

  assign w_act = r_act;
`else
  logic w_unused_strb;

  assign w_unused_strb = i_strb;
  assign w_act         = r_pend;
`endif

  assign w_on = (i_cnt < w_act);

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) r_led <= ACT_LOW;
    else          r_led <= ACT_LOW ? ~w_on : w_on;
  end

  assign o_duty = r_pend;
  assign o_led  = r_led;

endmodule

// File: rtl/pwm_duty_bank.sv
// Bank of N_CH PWM channels sharing one period counter and end-of-period strobe.
// Macro PWM_SHADOW_EN selects period-synchronous duty updates (see pwm_duty_ch).
module pwm_duty_bank
  import pwm_pkg::*;
#(
  parameter int N_CH     = PWM_N_CH,
  parameter int CW       = PWM_CW,
  parameter int DUTY_MAX = PWM_DUTY_MAX,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic            CLK,
  input  logic            CLR_N,
  pwm_duty_bank_if.slave  bus
);

  localparam logic [CW-1:0] LAST = CW'(DUTY_MAX - 1);

  logic [CW-1:0]               r_cnt;
  logic                        w_strb;
  logic [N_CH-1:0][CW-1:0]     w_duty;
  logic [N_CH-1:0]             w_led;

  assign w_strb = (r_cnt == LAST);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)      r_cnt <= '0;
    else if (w_strb) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_duty_ch #(
      .CW       (CW),
      .DUTY_MAX (DUTY_MAX),
      .ACT_LOW  (ACT_LOW)
    ) u_ch (
      .i_clk   (CLK),
      .i_clr_n (CLR_N),
      .i_incr  (bus.INCR),
      .i_dir   (bus.DIR),
      .i_wrap  (bus.WRAP),
      .i_sel   (bus.SEL[k]),
      .i_strb  (w_strb),
      .i_cnt   (r_cnt),
      .o_duty  (w_duty[k]),
      .o_led   (w_led[k])
    );
  end

  assign bus.DUTY     = w_duty;
  assign bus.LED_OUT  = w_led;
  assign bus.PER_STRB = w_strb;

endmodule

// File: tb/tb_pwm_duty_bank.sv
// Self-checking bench for pwm_duty_bank: per-cycle behavioural model plus directed literal checks.
// Honours PWM_SHADOW_EN the same way as the design build.
module tb_pwm_duty_bank;

  localparam int DM = 10;

  logic clk = 1'b0;
  logic rst_n;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pwm_duty_bank_if #(.N_CH(3), .CW(4)) bus ();
  pwm_duty_bank_if #(.N_CH(4), .CW(5)) bus2 ();

  pwm_duty_bank #(.N_CH(3), .CW(4), .DUTY_MAX(10), .ACT_LOW(1'b1)) dut (
    .CLK   (clk),
    .CLR_N (rst_n),
    .bus   (bus)
  );

  pwm_duty_bank #(.N_CH(4), .CW(5), .DUTY_MAX(20), .ACT_LOW(1'b0)) dut2 (
    .CLK   (clk),
    .CLR_N (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release, pending/active duty per channel, expected LED.
  int         m_edges;
  int         m_pend [3];
  int         m_act  [3];
  logic [2:0] m_led;

  task automatic model_reset();
    m_edges = 0;
    m_led   = 3'b111;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0;
      m_act[k]  = 0;
    end
  endtask

  task automatic model_step();
    int pos;
    int eff;
    pos = m_edges % DM;
    for (int k = 0; k < 3; k++) begin
`ifdef PWM_SHADOW_EN
      eff = m_act[k];
`else
      eff = m_pend[k];
`endif
      m_led[k] = !(pos < eff);
    end
    if (pos == DM - 1)
      for (int k = 0; k < 3; k++) m_act[k] = m_pend[k];
    for (int k = 0; k < 3; k++) begin
      if (bus.INCR && bus.SEL[k]) begin
        if (bus.DIR == 1'b0) m_pend[k] = (m_pend[k] == DM) ? (bus.WRAP ? 0 : DM) : m_pend[k] + 1;
        else                 m_pend[k] = (m_pend[k] == 0) ? (bus.WRAP ? DM : 0) : m_pend[k] - 1;
      end
    end
    m_edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    logic [11:0] ed;
    wait (started);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) ed[k*4 +: 4] = 4'(m_pend[k]);
      chk("model_duty", 32'(bus.DUTY), 32'(ed));
      chk("model_led", 32'(bus.LED_OUT), 32'(m_led));
      chk("model_strb", 32'(bus.PER_STRB), 32'(rst_n && ((m_edges % DM) == DM - 1)));
    end
  end

  task automatic pulse();
    bus.INCR = 1'b1;
    @(negedge clk);
    bus.INCR = 1'b0;
  endtask

  task automatic wait_strb(input bit second, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = second ? bus2.PER_STRB : bus.PER_STRB;
    end
    if (!ok) chk("strb_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int low [3];
    int nstrb;
    int gap;
    bit ok;
    rst_n = 1'b1;
    bus.INCR = 1'b0; bus.DIR = 1'b0; bus.SEL = '0; bus.WRAP = 1'b0;
    bus2.INCR = 1'b0; bus2.DIR = 1'b0; bus2.SEL = '0; bus2.WRAP = 1'b0;
    #2 rst_n = 1'b0;
    started = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(bus.DUTY), 32'h0);
    chk("rst_led", 32'(bus.LED_OUT), 32'h7);
    chk("rst_strb", 32'(bus.PER_STRB), 32'h0);
    chk("rst_led2", 32'(bus2.LED_OUT), 32'h0);
    rst_n = 1'b1;

    // Up-count with wrap on channel 0.
    bus.SEL = 3'b001; bus.DIR = 1'b0; bus.WRAP = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      pulse();
      chk("up_wrap_ch0", 32'(bus.DUTY[3:0]), 32'(i % 11));
    end

    // Saturating down-step at 0, then wrap to max.
    bus.SEL = 3'b010; bus.DIR = 1'b1; bus.WRAP = 1'b0;
    repeat (3) begin
      pulse();
      chk("dn_sat_ch1", 32'(bus.DUTY[7:4]), 32'd0);
    end
    bus.WRAP = 1'b1;
    pulse();
    chk("dn_wrap_ch1", 32'(bus.DUTY[7:4]), 32'd10);

    // Build {ch2=10, ch1=5, ch0=0}.
    repeat (5) pulse();
    bus.SEL = 3'b100;
    pulse();
    chk("duty_set", 32'(bus.DUTY), 32'hA50);
    bus.SEL = 3'b000;
    pulse();
    chk("sel_zero_hold", 32'(bus.DUTY), 32'hA50);

    repeat (12) @(negedge clk);
    low = '{0, 0, 0};
    nstrb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 10) for (int k = 0; k < 3; k++) low[k] += int'(!bus.LED_OUT[k]);
      nstrb += int'(bus.PER_STRB);
    end
    chk("low_ch0", 32'(low[0]), 32'd0);
    chk("low_ch1", 32'(low[1]), 32'd5);
    chk("low_ch2", 32'(low[2]), 32'd10);
    chk("strb_per_30", 32'(nstrb), 32'd3);

    // Raise ch0 to 2, align to a period, then step it to 7 early in that period.
    bus.SEL = 3'b001; bus.DIR = 1'b0;
    repeat (2) pulse();
    wait_strb(1'b0, ok);
    @(negedge clk);
    low[0] = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      low[0] += int'(!bus.LED_OUT[0]);
      bus.INCR = (j < 5);
    end
`ifdef PWM_SHADOW_EN
    chk("shadow_cur_low", 32'(low[0]), 32'd2);
`else
    chk("direct_cur_low", 32'(low[0]), 32'd7);
`endif
    chk("ch0_is_7", 32'(bus.DUTY[3:0]), 32'd7);
    low[0] = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      low[0] += int'(!bus.LED_OUT[0]);
    end
    chk("next_period_low", 32'(low[0]), 32'd7);

    // Step all channels on the strobe cycle: {10,5,7} -> {0,6,8}.
    bus.SEL = 3'b111; bus.WRAP = 1'b1;
    wait_strb(1'b0, ok);
    pulse();
    chk("incr_at_strb", 32'(bus.DUTY), 32'h068);

    // Mid-period asynchronous reset.
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_duty", 32'(bus.DUTY), 32'h0);
    chk("async_led", 32'(bus.LED_OUT), 32'h7);
    chk("async_strb", 32'(bus.PER_STRB), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.SEL = 3'b001; bus.DIR = 1'b0;
    pulse();
    chk("incr_first_edge", 32'(bus.DUTY), 32'h001);
    bus.SEL = 3'b000;

    // Wider configuration: period 20, up-wrap at 20.
    bus2.SEL = 4'b0001; bus2.DIR = 1'b0; bus2.WRAP = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus2.INCR = 1'b1;
      @(negedge clk);
    end
    bus2.INCR = 1'b0;
    chk("w_duty_max", 32'(bus2.DUTY[4:0]), 32'd20);
    bus2.INCR = 1'b1;
    @(negedge clk);
    bus2.INCR = 1'b0;
    chk("w_wrap_zero", 32'(bus2.DUTY[4:0]), 32'd0);
    wait_strb(1'b1, ok);
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      gap++;
      ok = bus2.PER_STRB;
    end
    chk("w_period", 32'(gap), 32'd20);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
